// File: rtl/lighting_pkg.sv
// Shared types and helpers for the multi-channel lamp controller.
// Holds the per-channel state encoding and output decode functions.
package lighting_pkg;

  typedef enum logic [2:0] {
    AUTO_OFF   = 3'd0,
    AUTO_ON    = 3'd1,
    AUTO_HOLD  = 3'd2,
    MANUAL_OFF = 3'd3,
    MANUAL_ON  = 3'd4
  } light_state_t;

  function automatic logic is_manual(
    input light_state_t s
  );
    return (s == MANUAL_OFF) ||
           (s == MANUAL_ON);
  endfunction

  function automatic logic is_on(
    input light_state_t s
  );
    return (s == AUTO_ON) ||
           (s == AUTO_HOLD) ||
           (s == MANUAL_ON);
  endfunction

endpackage

// File: rtl/light_channel.sv
// One lamp channel: button edge detect, auto/manual FSM,
// and the hold-time counter used after presence drops.
module light_channel
  import lighting_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W = $clog2(HOLD_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_btn,
  input  logic toggle_btn,
  input  logic presence,
  input  logic all_off,
  output logic led,
  output logic saida
);

  localparam logic [CNT_W-1:0] HOLD_LOAD =
    CNT_W'(HOLD_CYCLES - 1);

  logic         r_mode_q;
  logic         r_tog_q;
  light_state_t r_state;
  light_state_t w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic         w_mode_edge;
  logic         w_tog_edge;

  assign w_mode_edge = mode_btn & ~r_mode_q;
  assign w_tog_edge  = toggle_btn & ~r_tog_q;

  // Button history resets high so a held button gives no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q <= 1'b1;
      r_tog_q  <= 1'b1;
    end else begin
      r_mode_q <= mode_btn;
      r_tog_q  <= toggle_btn;
    end
  end

  // Next state: all_off beats mode edge beats the rest.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (all_off) begin
      w_cnt_next = '0;
      w_next = is_manual(r_state) ?
               MANUAL_OFF : AUTO_OFF;
    end else if (w_mode_edge) begin
      case (r_state)
        AUTO_OFF:   w_next = MANUAL_OFF;
        AUTO_ON:    w_next = MANUAL_ON;
        AUTO_HOLD:  w_next = MANUAL_ON;
        MANUAL_OFF: w_next = AUTO_OFF;
        MANUAL_ON:  w_next = AUTO_ON;
        default: begin
          w_next     = AUTO_OFF;
          w_cnt_next = '0;
        end
      endcase
    end else begin
      case (r_state)
        AUTO_OFF: begin
          if (presence) w_next = AUTO_ON;
        end
        AUTO_ON: begin
          if (!presence) begin
            w_next     = AUTO_HOLD;
            w_cnt_next = HOLD_LOAD;
          end
        end
        AUTO_HOLD: begin
          if (presence) begin
            w_next = AUTO_ON;
          end else if (r_cnt == '0) begin
            w_next = AUTO_OFF;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        MANUAL_OFF: begin
          if (w_tog_edge) w_next = MANUAL_ON;
        end
        MANUAL_ON: begin
          if (w_tog_edge) w_next = MANUAL_OFF;
        end
        default: begin
          w_next     = AUTO_OFF;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  // State and hold counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= AUTO_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign led   = is_manual(r_state);
  assign saida = is_on(r_state);

endmodule

// File: rtl/lighting_ctrl_multi.sv
// Multi-channel lamp controller: independent channels,
// broadcast all-off and an aggregate any-lamp-on flag.
module lighting_ctrl_multi
  import lighting_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W = $clog2(HOLD_CYCLES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] mode_btn,
  input  logic [CHANNELS-1:0] toggle_btn,
  input  logic [CHANNELS-1:0] presence,
  input  logic                all_off,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] saida,
  output logic                any_on
);

  // One controller per lamp, sharing only clock, reset, all_off.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    light_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .mode_btn   (mode_btn[g]),
      .toggle_btn (toggle_btn[g]),
      .presence   (presence[g]),
      .all_off    (all_off),
      .led        (led[g]),
      .saida      (saida[g])
    );
  end

  assign any_on = |saida;

endmodule

// File: tb/tb_lighting_ctrl_multi.sv
// Directed bench for lighting_ctrl_multi (4 channels, hold 4).
// Expected outputs are queued per step and checked after the edge.
module tb_lighting_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode_btn;
  logic [3:0] toggle_btn;
  logic [3:0] presence;
  logic       all_off;
  logic [3:0] led;
  logic [3:0] saida;
  logic       any_on;

  typedef struct {
    logic [3:0] led;
    logic [3:0] saida;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  lighting_ctrl_multi #(
    .CHANNELS    (4),
    .HOLD_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_btn   (mode_btn),
    .toggle_btn (toggle_btn),
    .presence   (presence),
    .all_off    (all_off),
    .led        (led),
    .saida      (saida),
    .any_on     (any_on)
  );

  always #5 clk = ~clk;

  task automatic compare();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard empty got 0 want 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (led === e.led) else begin
        errors++;
        $error("FAIL %s led got %b want %b",
               e.tag, led, e.led);
      end
      checks++;
      assert (saida === e.saida) else begin
        errors++;
        $error("FAIL %s saida got %b want %b",
               e.tag, saida, e.saida);
      end
      checks++;
      assert (any_on === (|e.saida)) else begin
        errors++;
        $error("FAIL %s any_on got %b want %b",
               e.tag, any_on, |e.saida);
      end
    end
  endtask

  task automatic tick(input logic [3:0] el,
                      input logic [3:0] es,
                      input string tag);
    exp_t e;
    e.led = el;
    e.saida = es;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic now(input logic [3:0] el,
                     input logic [3:0] es,
                     input string tag);
    exp_t e;
    e.led = el;
    e.saida = es;
    e.tag = tag;
    sb.push_back(e);
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1;
    mode_btn = 4'b0001;
    toggle_btn = 4'b0000;
    presence = 4'b0000;
    all_off = 1'b0;

    // reset with ch0 mode button held
    tick(4'b0000, 4'b0000, "rst_a");
    tick(4'b0000, 4'b0000, "rst_b");
    rst = 1'b0;
    tick(4'b0000, 4'b0000, "held0");
    tick(4'b0000, 4'b0000, "held1");
    mode_btn = 4'b0000;
    tick(4'b0000, 4'b0000, "rel0");
    mode_btn = 4'b0001;
    tick(4'b0001, 4'b0000, "press0");
    mode_btn = 4'b0000;
    tick(4'b0001, 4'b0000, "rel0b");
    mode_btn = 4'b0001;
    tick(4'b0000, 4'b0000, "back0");
    mode_btn = 4'b0000;
    tick(4'b0000, 4'b0000, "rel0c");

    // ch1 presence then exact hold
    presence = 4'b0010;
    tick(4'b0000, 4'b0010, "p1_on");
    tick(4'b0000, 4'b0010, "p1_h1");
    tick(4'b0000, 4'b0010, "p1_h2");
    presence = 4'b0000;
    tick(4'b0000, 4'b0010, "hold1_0");
    tick(4'b0000, 4'b0010, "hold1_1");
    tick(4'b0000, 4'b0010, "hold1_2");
    tick(4'b0000, 4'b0010, "hold1_3");
    tick(4'b0000, 4'b0000, "hold1_off");

    // re-trigger during hold reloads full time
    presence = 4'b0010;
    tick(4'b0000, 4'b0010, "rt_on");
    presence = 4'b0000;
    tick(4'b0000, 4'b0010, "rt_h0");
    tick(4'b0000, 4'b0010, "rt_h1");
    presence = 4'b0010;
    tick(4'b0000, 4'b0010, "rt_back");
    presence = 4'b0000;
    tick(4'b0000, 4'b0010, "rt2_0");
    tick(4'b0000, 4'b0010, "rt2_1");
    tick(4'b0000, 4'b0010, "rt2_2");
    tick(4'b0000, 4'b0010, "rt2_3");
    tick(4'b0000, 4'b0000, "rt2_off");

    // ch2 manual toggling, presence ignored
    mode_btn = 4'b0100;
    tick(4'b0100, 4'b0000, "m2_man");
    mode_btn = 4'b0000;
    tick(4'b0100, 4'b0000, "m2_rel");
    toggle_btn = 4'b0100;
    tick(4'b0100, 4'b0100, "t2_on");
    toggle_btn = 4'b0000;
    presence = 4'b0100;
    tick(4'b0100, 4'b0100, "t2_p1");
    presence = 4'b0000;
    tick(4'b0100, 4'b0100, "t2_p0");
    tick(4'b0100, 4'b0100, "t2_w3");
    tick(4'b0100, 4'b0100, "t2_w4");
    toggle_btn = 4'b0100;
    tick(4'b0100, 4'b0000, "t2_off");
    toggle_btn = 4'b0000;
    tick(4'b0100, 4'b0000, "t2_rel");
    toggle_btn = 4'b0100;
    tick(4'b0100, 4'b0100, "t2_on2");
    toggle_btn = 4'b0000;
    tick(4'b0100, 4'b0100, "t2_rel2");

    // toggle on an auto channel does nothing
    toggle_btn = 4'b0010;
    tick(4'b0100, 4'b0100, "t1_auto");
    toggle_btn = 4'b0000;
    tick(4'b0100, 4'b0100, "t1_rel");

    // ch3 auto-on -> manual-on -> auto-on -> hold
    presence = 4'b1000;
    tick(4'b0100, 4'b1100, "p3_on");
    mode_btn = 4'b1000;
    tick(4'b1100, 4'b1100, "m3_man");
    mode_btn = 4'b0000;
    presence = 4'b0000;
    tick(4'b1100, 4'b1100, "m3_nop");
    mode_btn = 4'b1000;
    tick(4'b0100, 4'b1100, "m3_auto");
    mode_btn = 4'b0000;
    tick(4'b0100, 4'b1100, "h3_0");
    tick(4'b0100, 4'b1100, "h3_1");
    tick(4'b0100, 4'b1100, "h3_2");
    tick(4'b0100, 4'b1100, "h3_3");
    tick(4'b0100, 4'b0100, "h3_off");

    // all_off with simultaneous mode edge on ch2
    presence = 4'b0001;
    tick(4'b0100, 4'b0101, "p0_on");
    presence = 4'b0000;
    tick(4'b0100, 4'b0101, "p0_hold");
    all_off = 1'b1;
    mode_btn = 4'b0100;
    tick(4'b0100, 4'b0000, "alloff");
    all_off = 1'b0;
    tick(4'b0100, 4'b0000, "ao_held");
    mode_btn = 4'b0000;
    tick(4'b0100, 4'b0000, "ao_rel");

    // all_off held keeps auto lamps off
    presence = 4'b0010;
    all_off = 1'b1;
    tick(4'b0100, 4'b0000, "aoh_0");
    tick(4'b0100, 4'b0000, "aoh_1");
    all_off = 1'b0;
    tick(4'b0100, 4'b0010, "aoh_on");
    presence = 4'b0000;
    tick(4'b0100, 4'b0010, "pre_r0");
    tick(4'b0100, 4'b0010, "pre_r1");

    // async reset mid-hold, no clock edge
    #2;
    rst = 1'b1;
    now(4'b0000, 4'b0000, "async");
    tick(4'b0000, 4'b0000, "in_rst");
    rst = 1'b0;
    tick(4'b0000, 4'b0000, "post_rst");
    presence = 4'b0010;
    tick(4'b0000, 4'b0010, "pr_on");
    presence = 4'b0000;
    tick(4'b0000, 4'b0010, "pr_h0");
    tick(4'b0000, 4'b0010, "pr_h1");
    tick(4'b0000, 4'b0010, "pr_h2");
    tick(4'b0000, 4'b0010, "pr_h3");
    tick(4'b0000, 4'b0000, "pr_off");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/lighting_ctrl_multi.md
# lighting_ctrl_multi

Parametrised multi-channel lamp controller and the successor to the single-lamp auto/manual controller. Each of `CHANNELS` independent lamps runs its own auto/manual mode FSM. In auto mode a lamp follows a presence sensor and stays on for a programmable hold time after presence drops. Also provides a global all-off control and an aggregate any-lamp-on status; sits between the synchronised button/sensor inputs and the lamp drivers.

## Interface
- `CHANNELS`, 4: number of independent lamp channels (≥1).
- `HOLD_CYCLES`, 1000: cycles a lamp stays on in auto mode after presence drops (≥1).
- `CNT_W`, `$clog2(HOLD_CYCLES)+1`: hold counter width (derived, not overridden).
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode_btn`  in  CHANNELS  per-channel mode toggle button, level; rising edge acts.
- `toggle_btn`  in  CHANNELS  per-channel manual on/off button, level; rising edge acts.
- `presence`  in  CHANNELS  per-channel presence sensor, level.
- `all_off`  in  1  global force-off, level, synchronous.
- `led`  out  CHANNELS  1 = channel in manual mode.
- `saida`  out  CHANNELS  1 = lamp on.
- `any_on`  out  1  OR of all `saida` bits.

All inputs are already synchronous to `clk`; synchronisers and debouncers sit upstream.

## Operation
- Per-channel edge detect: `btn_q` registers; edge = `btn & ~btn_q`. `btn_q` resets to 1, so a button held through reset release produces no edge.
- States per channel: `AUTO_OFF`, `AUTO_ON`, `AUTO_HOLD`, `MANUAL_OFF`, `MANUAL_ON`.
- Priority, evaluated each cycle: `all_off` > mode edge > toggle edge / presence / counter.
- `all_off`=1:
  - `AUTO_*` goes to `AUTO_OFF`; `MANUAL_*` goes to `MANUAL_OFF`.
  - Edges seen in the same cycle are discarded.
  - The counter is cleared.
- Mode edge:
  - `AUTO_OFF` → `MANUAL_OFF`.
  - `AUTO_ON` or `AUTO_HOLD` → `MANUAL_ON`.
  - `MANUAL_OFF` → `AUTO_OFF`.
  - `MANUAL_ON` → `AUTO_ON`. If presence=0, the next cycle enters `AUTO_HOLD` by the normal rule.
- `AUTO_OFF`: presence=1 → `AUTO_ON`.
- `AUTO_ON`: presence=0 → `AUTO_HOLD`, counter loaded with `HOLD_CYCLES-1`.
- `AUTO_HOLD`:
  - presence=1 → `AUTO_ON` (counter abandoned).
  - Else if counter==0 → `AUTO_OFF`.
  - Else decrement the counter.
- `MANUAL_OFF` ↔ `MANUAL_ON` on each toggle edge. Presence is ignored in manual mode; toggle edges are ignored in auto mode.
- Illegal state encoding → `AUTO_OFF` on the next edge.
- Outputs are Moore, decoded from the state register:
  - `led` = `MANUAL_*`.
  - `saida` = `AUTO_ON | AUTO_HOLD | MANUAL_ON`.
  - `any_on` = |`saida`.

## Timing
- Reset (async assert, sync-safe release): every channel in `AUTO_OFF`, counter 0, `btn_q`=1. Outputs: `led`=0, `saida`=0, `any_on`=0.
- Latency: an input event sampled at edge k changes the state at edge k; the output reflects it after edge k (one cycle from input setup).
- Hold: presence seen low at edge k gives `AUTO_HOLD` with `saida`=1. `AUTO_OFF` is reached at edge k+`HOLD_CYCLES`, so `saida` stays high for exactly `HOLD_CYCLES` cycles after the state change.
- Presence returning at any edge during hold → `AUTO_ON` at that edge. A later drop reloads the full hold time.
- `all_off` held: auto channels stay off while it is asserted. The first edge after release with presence=1 turns the lamp on.
- Channels are fully independent; simultaneous events on different channels never interact.

## Structure
- Shared package `lighting_pkg`:
  - `light_state_t`, 3-bit enum of the five states.
  - Helper functions `is_manual()` and `is_on()` used for output decode.
- Sub-module `light_channel`: one channel (edge detect, FSM, hold counter), parameters `HOLD_CYCLES` and `CNT_W`, plus an `all_off` input.
- Top-level `lighting_ctrl_multi`: a generate loop over `light_channel`, `all_off` broadcast, and the `any_on` reduction.

## Test plan
Bench uses `CHANNELS`=4, `HOLD_CYCLES`=4.
- Reset with `mode_btn[0]` held high, then release → `led`=0000, `saida`=0000, no mode change on ch0 until the button is released and pressed again.
- Presence[1] high 3 cycles then low → `saida[1]` rises one cycle after presence, stays high exactly 4 cycles after the drop, then clears. Presence re-asserted at hold cycle 2 → remains on, and the next drop gives a full 4-cycle hold.
- Mode edge on ch2 → `led[2]`=1. Toggle edges at t and t+5 → `saida[2]` on, then off. Presence[2] pulses meanwhile → no effect.
- Ch3 in `AUTO_ON`, mode edge → `MANUAL_ON` (`led`=1, `saida`=1). Second mode edge with presence=0 → `AUTO_ON`, then hold, then off after 4 cycles.
- Channels mixed on (ch0 auto-hold, ch2 manual-on), pulse `all_off` with a simultaneous `mode_btn[2]` edge → all `saida`=0, `any_on`=0; `led[2]` stays 1 (mode edge discarded).
- Async `rst` asserted mid-hold on ch1 → outputs 0 immediately without a clock edge. After release, ch1 is in `AUTO_OFF` with the counter cleared.
